// File: rtl/fifo_wr_arb_pkg.sv
// rtl/fifo_wr_arb_pkg.sv - shared defaults, derived widths and state type for the FIFO write arbiter
package fifo_wr_arb_pkg;

    localparam int NUM_REQ_DEF    = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int BURST_LEN_DEF  = 4;

    // Keeps single-requester builds from producing zero-width vectors.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W_DEF = idx_width(NUM_REQ_DEF);
    localparam int CNT_W_DEF = idx_width(BURST_LEN_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_wr_arb_if.sv
// rtl/fifo_wr_arb_if.sv - producer handshake and FIFO write-port bundle for the arbiter
interface fifo_wr_arb_if
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    localparam int IDX_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_data;
    logic [IDX_W-1:0]              owner;
    logic                          busy;

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_data, owner, busy
    );

    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_data, owner, busy
    );

endinterface

// File: rtl/fifo_wr_arb_rr_pick.sv
// rtl/fifo_wr_arb_rr_pick.sv - combinational round-robin search starting one past the last owner
module rr_pick
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    localparam int IDX_W  = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_found
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand = IDX_W'((int'(i_last) + i) % NUM_REQ);
            if (!o_found && i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin burst arbiter sharing one FIFO write port among producers
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BURST_LEN  = BURST_LEN_DEF
) (
    input  logic          clk,
    input  logic          rst,
    fifo_wr_arb_if.slave  bus
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = idx_width(BURST_LEN);

    state_t             r_state;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_last;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic               r_busy;

    logic [IDX_W-1:0]   w_pick;
    logic               w_found;
    logic               w_owner_valid;
    logic               w_accept;
    logic [NUM_REQ-1:0] w_ready;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .i_req   (bus.req_valid),
        .i_last  (r_last),
        .o_idx   (w_pick),
        .o_found (w_found)
    );

    assign w_owner_valid = bus.req_valid[r_owner];
    assign w_accept      = r_busy && w_owner_valid && !bus.fifo_full;

    // Both burst-end conditions release the grant and become the next round-robin origin.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_last     <= IDX_W'(NUM_REQ - 1);
            r_beat_cnt <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state    <= BUSY;
                        r_busy     <= 1'b1;
                        r_owner    <= w_pick;
                        r_beat_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (!w_owner_valid) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_last  <= r_owner;
                    end else if (!bus.fifo_full) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (r_beat_cnt == CNT_W'(BURST_LEN - 1)) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_last  <= r_owner;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_ready = '0;
        if (r_busy) begin
            w_ready[r_owner] = !bus.fifo_full;
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.fifo_wr_en = w_accept;
    assign bus.fifo_data  = r_busy ? bus.req_data[r_owner*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.owner      = r_owner;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - randomized and directed bench for fifo_wr_arb against a burst-level model
module tb_fifo_wr_arb;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BL = 4;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    fifo_wr_arb_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: who holds the grant, how many beats it may still send, who had it last.
    bit        m_busy;
    int        m_owner;
    int        m_left;
    int        m_last;
    bit        e_busy;
    int        e_owner;
    logic [3:0] e_ready;
    bit        e_wr;
    logic [7:0] e_data;

    logic [7:0] wlog[$];
    int         wcyc[$];
    int         glog[$];
    bit         prev_busy;

    function automatic int rr_first(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_left = 0; m_last = N - 1;
        wlog.delete(); wcyc.delete(); glog.delete(); prev_busy = 0;
    endtask

    task automatic apply(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic f);
        int k;
        @(negedge clk);
        bus.req_valid = v; bus.req_data = d; bus.fifo_full = f;
        #1;
        e_busy  = m_busy;
        e_owner = m_owner;
        e_ready = (m_busy && !f) ? 4'(1 << m_owner) : 4'h0;
        e_wr    = m_busy && v[m_owner] && !f;
        e_data  = m_busy ? d[m_owner*DW +: DW] : 8'h00;
        if (bus.fifo_wr_en) begin wlog.push_back(bus.fifo_data); wcyc.push_back(cyc); end
        if (bus.busy && !prev_busy) glog.push_back(int'(bus.owner));
        prev_busy = bus.busy;
        if (!m_busy) begin
            k = rr_first(v, m_last);
            if (k >= 0) begin m_busy = 1; m_owner = k; m_left = BL; end
        end else if (!v[m_owner]) begin
            m_busy = 0; m_last = m_owner;
        end else if (!f) begin
            m_left--;
            if (m_left == 0) begin m_busy = 0; m_last = m_owner; end
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = '0; bus.req_data = '0; bus.fifo_full = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 4'hF; bus.req_data = $urandom; bus.fifo_full = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready: got %h expected 0", bus.req_ready); end
        checks++; if (bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", bus.fifo_wr_en); end
        checks++; if (bus.fifo_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.fifo_data); end
        checks++; if (bus.owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", bus.owner); end
        do_reset();
    endtask

    task automatic test_all_four();
        do_reset();
        repeat (20) begin
            apply(4'hF, 32'h13121110, 1'b0);
            checks++;
            if ({bus.busy, bus.req_ready, bus.fifo_wr_en, bus.fifo_data} !== {e_busy, e_ready, e_wr, e_data}) begin
                errors++;
                $display("FAIL all4_cycle%0d: got busy=%b rdy=%h wr=%b data=%h expected busy=%b rdy=%h wr=%b data=%h",
                         cyc, bus.busy, bus.req_ready, bus.fifo_wr_en, bus.fifo_data, e_busy, e_ready, e_wr, e_data);
            end
        end
        checks++; if (glog.size() != 4) begin errors++; $display("FAIL all4_grants: got %0d expected 4", glog.size()); end
        for (int k = 0; k < glog.size() && k < 4; k++) begin
            checks++; if (glog[k] != k) begin errors++; $display("FAIL all4_order%0d: got %0d expected %0d", k, glog[k], k); end
        end
        checks++; if (wlog.size() != 16) begin errors++; $display("FAIL all4_writes: got %0d expected 16", wlog.size()); end
        for (int k = 0; k < wlog.size() && k < 16; k++) begin
            checks++; if (wlog[k] !== 8'(8'h10 + k / 4)) begin errors++; $display("FAIL all4_data%0d: got %h expected %h", k, wlog[k], 8'(8'h10 + k / 4)); end
            if (k % 4 != 0) begin
                checks++; if (wcyc[k] - wcyc[k-1] != 1) begin errors++; $display("FAIL all4_gap%0d: got %0d expected 1", k, wcyc[k] - wcyc[k-1]); end
            end
        end
    endtask

    task automatic test_single_drop();
        logic [7:0]  d8;
        logic [31:0] dd;
        d8 = 8'($urandom);
        dd = {8'h00, d8, 16'h0000};
        do_reset();
        apply(4'b0100, dd, 1'b0);
        apply(4'b0100, dd, 1'b0);
        apply(4'b0100, dd, 1'b0);
        apply(4'b0000, dd, 1'b0);
        checks++; if ({bus.busy, bus.fifo_wr_en} !== 2'b10) begin errors++; $display("FAIL drop_cycle: got busy/wr=%b expected 10", {bus.busy, bus.fifo_wr_en}); end
        apply(4'b0000, dd, 1'b0);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got %b expected 0", bus.busy); end
        checks++; if (wlog.size() != 2) begin errors++; $display("FAIL drop_writes: got %0d expected 2", wlog.size()); end
        for (int k = 0; k < wlog.size() && k < 2; k++) begin
            checks++; if (wlog[k] !== d8) begin errors++; $display("FAIL drop_data%0d: got %h expected %h", k, wlog[k], d8); end
        end
        apply(4'hF, dd, 1'b0);
        apply(4'hF, dd, 1'b0);
        checks++; if ({bus.busy, bus.owner} !== 3'b111) begin errors++; $display("FAIL drop_last_owner: got busy=%b owner=%0d expected busy=1 owner=3", bus.busy, bus.owner); end
    endtask

    task automatic test_full_stall();
        logic [31:0] dd;
        dd = $urandom;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            apply(4'b0010, dd, (c >= 3 && c <= 5));
            if (c >= 3 && c <= 5) begin
                checks++;
                if ({bus.fifo_wr_en, bus.req_ready[1], bus.busy, bus.owner} !== {1'b0, 1'b0, 1'b1, 2'd1}) begin
                    errors++;
                    $display("FAIL stall_c%0d: got wr=%b rdy1=%b busy=%b owner=%0d expected wr=0 rdy1=0 busy=1 owner=1",
                             c, bus.fifo_wr_en, bus.req_ready[1], bus.busy, bus.owner);
                end
            end
        end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stall_end_busy: got %b expected 0", bus.busy); end
        checks++; if (wlog.size() != 4) begin errors++; $display("FAIL stall_writes: got %0d expected 4", wlog.size()); end
        for (int k = 0; k < wlog.size() && k < 4; k++) begin
            checks++; if (wlog[k] !== dd[15:8]) begin errors++; $display("FAIL stall_data%0d: got %h expected %h", k, wlog[k], dd[15:8]); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] dd;
        dd = $urandom;
        do_reset();
        for (int c = 0; c < 15; c++)
            apply((c >= 4) ? 4'b1001 : 4'b1000, dd, 1'b0);
        checks++; if (glog.size() != 3) begin errors++; $display("FAIL wrap_grants: got %0d expected 3", glog.size()); end
        for (int k = 0; k < glog.size() && k < 3; k++) begin
            checks++; if (glog[k] != ((k == 1) ? 0 : 3)) begin errors++; $display("FAIL wrap_order%0d: got %0d expected %0d", k, glog[k], (k == 1) ? 0 : 3); end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] dd;
        dd = $urandom;
        do_reset();
        apply(4'b0011, dd, 1'b0);
        apply(4'b0011, dd, 1'b0);
        checks++; if (bus.fifo_wr_en !== 1'b1) begin errors++; $display("FAIL arst_pre_wr: got %b expected 1", bus.fifo_wr_en); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL arst_ready: got %h expected 0", bus.req_ready); end
        checks++; if (bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL arst_wr_en: got %b expected 0", bus.fifo_wr_en); end
        bus.req_valid = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        apply(4'b0011, dd, 1'b0);
        apply(4'b0011, dd, 1'b0);
        checks++; if ({bus.busy, bus.owner} !== 3'b100) begin errors++; $display("FAIL arst_first_grant: got busy=%b owner=%0d expected busy=1 owner=0", bus.busy, bus.owner); end
    endtask

    task automatic test_random();
        logic [N-1:0]    v;
        logic [N*DW-1:0] d;
        logic            f;
        do_reset();
        v = 4'hF;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) v = 4'($urandom);
            f = ($urandom_range(0, 3) == 0);
            d = $urandom;
            apply(v, d, f);
            checks++;
            if ({bus.busy, bus.req_ready, bus.fifo_wr_en, bus.fifo_data} !== {e_busy, e_ready, e_wr, e_data}) begin
                errors++;
                $display("FAIL rand_cycle%0d: got busy=%b rdy=%h wr=%b data=%h expected busy=%b rdy=%h wr=%b data=%h",
                         c, bus.busy, bus.req_ready, bus.fifo_wr_en, bus.fifo_data, e_busy, e_ready, e_wr, e_data);
            end
            if (e_busy) begin
                checks++;
                if (bus.owner !== 2'(e_owner)) begin errors++; $display("FAIL rand_owner%0d: got %0d expected %0d", c, bus.owner, e_owner); end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.req_valid = '0; bus.req_data = '0; bus.fifo_full = 1'b0;
        model_reset();
        test_reset();
        test_all_four();
        test_single_drop();
        test_full_stall();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of producers sharing one sync FIFO write port.
REQ-002 Parameter DATA_WIDTH, default 8: beat width, equal to the FIFO data width.
REQ-003 Parameter BURST_LEN, default 4: maximum beats per grant, power of two, at least 2.
REQ-004 clk  input  1: single clock; all state is updated on its rising edge.
REQ-005 rst  input  1: asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
REQ-006 req_valid  input  NUM_REQ: per-producer beat-available flags.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH: packed beats; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_ready  output  NUM_REQ: per-producer accept flags; a beat transfers when valid and ready are both high.
REQ-009 fifo_full  input  1: full flag from the shared FIFO.
REQ-010 fifo_wr_en  output  1: FIFO write enable.
REQ-011 fifo_data  output  DATA_WIDTH: FIFO write data.
REQ-012 owner  output  log2(NUM_REQ): index of the current grant holder; the value is meaningful only while busy is high.
REQ-013 busy  output  1: high while a grant is held (state BUSY).

Function
REQ-014 The controller SHALL use two states: IDLE (no owner) and BUSY (owner locked).
REQ-015 In IDLE with any req_valid high, it SHALL pick the first valid requester in round-robin order, starting at last_owner+1 mod NUM_REQ, and enter BUSY on the next edge. Arbitration latency is 1 cycle, and no beat is accepted in IDLE.
REQ-016 In IDLE with no req_valid high, the controller SHALL stay in IDLE, and all outputs except owner SHALL be 0.
REQ-017 In BUSY, req_ready[owner] SHALL equal !fifo_full, combinationally; all other req_ready bits SHALL be 0.
REQ-018 fifo_wr_en SHALL equal busy && req_valid[owner] && !fifo_full, combinationally. fifo_data SHALL equal req_data slice [owner] while busy, and 0 otherwise.
REQ-019 Each accepted beat SHALL increment beat_cnt, which is log2(BURST_LEN) bits wide and cleared on every grant.
REQ-020 BUSY SHALL go to IDLE when a beat is accepted with beat_cnt == BURST_LEN-1, or when req_valid[owner] is low in a BUSY cycle. The owner SHALL then be recorded as last_owner.
REQ-021 fifo_full high SHALL stall the grant without releasing it: no beat, no count change, state held.
REQ-022 The write path SHALL never assert fifo_wr_en while fifo_full is high, so no write is dropped or overflows the FIFO.
REQ-023 Round-robin SHALL wrap from NUM_REQ-1 to 0. A requester that is continuously valid SHALL be granted within NUM_REQ grants.
REQ-024 A requester SHALL NOT be re-granted back-to-back while another requester is valid; it MAY be re-granted after an IDLE cycle when it is the only one valid.

Reset
REQ-025 While rst is low: state IDLE, beat_cnt 0, owner 0, last_owner NUM_REQ-1 (so requester 0 wins first), busy 0, req_ready 0, fifo_wr_en 0, fifo_data 0.
REQ-026 Reset asserted mid-burst SHALL drop the grant immediately, without waiting for a clock edge. The first post-reset arbitration SHALL again favour requester 0.

Structure
REQ-027 A shared package SHALL hold the NUM_REQ, DATA_WIDTH and BURST_LEN defaults, the derived index and count widths, and the state enum {IDLE, BUSY}.
REQ-028 One sub-module, rr_pick, SHALL be combinational: inputs are the request vector and last_owner, outputs are the next index and a found flag.
REQ-029 The FIFO itself SHALL remain external; this block connects only to its write port and full flag.

Verification
REQ-030 After reset, all four requesters valid with data 0x10..0x13: grants in order 0,1,2,3; each owner writes 4 beats; the FIFO receives 16 writes with no gaps inside a burst.
REQ-031 Only requester 2 valid, valid held for 2 beats then dropped: 2 writes of req_data[2]; IDLE the cycle after the drop; last_owner = 2.
REQ-032 fifo_full asserted for 3 cycles during beat 2 of requester 1: fifo_wr_en and req_ready[1] are 0 for those cycles; owner stays 1; beats 2..3 complete after full clears; 4 writes total.
REQ-033 Requesters 3 and 0 valid, last_owner = 3: requester 0 is granted, then requester 3, demonstrating the wrap from 3 to 0.
REQ-034 rst asserted asynchronously mid-burst, between clock edges: busy, req_ready and fifo_wr_en fall to 0 immediately. After release, with requesters 1 and 0 valid, requester 0 is granted first.
